// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults, walk-length constants and FSM state encoding for the FIR decimator control path
package fir_pkg;

    localparam int FIR_WIDTH    = 24;
    localparam int FIR_TAPS     = 64;
    localparam int FLUSH_CYCLES = 1;
    localparam int WALK_CYCLES  = FIR_TAPS + 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_MAC     = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_READ    = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;

endpackage

// File: rtl/fir_sample_buf.sv
// fir_sample_buf: circular sample store with one write port and a combinational read port, cleared on reset
module fir_sample_buf
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int TAPS  = FIR_TAPS,
    parameter int AW    = $clog2(TAPS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [TAPS];

    // Zero every slot on reset, otherwise store the strobed sample
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < TAPS; i++) r_mem[i] <= '0;
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: buffers samples, decimates, and sequences the MAC over all taps once per DECIM samples
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_WIDTH,
    parameter int TAPS  = FIR_TAPS,
    parameter int DECIM = 8,
    parameter int AW    = $clog2(TAPS)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_in_strobe,
    input  logic [WIDTH-1:0]   i_in_data,
    output logic [AW-1:0]      o_coef_addr,
    input  logic [WIDTH-1:0]   i_coef_data,
    output logic               o_mac_clr,
    output logic               o_mac_wren,
    output logic               o_mac_rden,
    output logic [WIDTH-1:0]   o_mac_m1,
    output logic [WIDTH-1:0]   o_mac_m2,
    input  logic [2*WIDTH-1:0] i_mac_accum,
    output logic               o_out_strobe,
    output logic [2*WIDTH-1:0] o_out_data,
    output logic               o_busy,
    output logic               o_overrun
);

    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [2:0]         r_state;
    logic [AW-1:0]      r_tap;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_newest;
    logic [DW-1:0]      r_dec;
    logic               r_overrun;
    logic [2*WIDTH-1:0] r_out_data;
    logic               w_trig;
    logic               w_busy;
    logic               w_tap_last;
    logic [WIDTH-1:0]   w_rd_data;

    assign w_trig     = i_in_strobe && (r_dec == DW'(DECIM - 1));
    assign w_busy     = (r_state != S_IDLE);
    assign w_tap_last = (r_tap == AW'(TAPS - 1));

    fir_sample_buf #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .AW    (AW)
    ) u_buf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (i_in_strobe),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_in_data),
        .i_rd_addr (r_newest - r_tap),
        .o_rd_data (w_rd_data)
    );

    // Every input strobe advances the write pointer and the decimation count, in any state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_dec    <= '0;
        end else if (i_in_strobe) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_dec    <= w_trig ? '0 : r_dec + 1'b1;
        end
    end

    // Walk sequencer: CLEAR, TAPS MAC cycles, FLUSH to drain the product stage, READ, CAPTURE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_tap    <= '0;
            r_newest <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_trig) begin
                    r_state  <= S_CLEAR;
                    r_newest <= r_wr_ptr;
                end
                S_CLEAR: begin
                    r_state <= S_MAC;
                    r_tap   <= '0;
                end
                S_MAC: begin
                    r_tap   <= r_tap + 1'b1;
                    r_state <= w_tap_last ? S_FLUSH : S_MAC;
                end
                S_FLUSH: r_state <= S_READ;
                S_READ:  r_state <= S_CAPTURE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sticky overrun on a trigger dropped while busy; hold the last captured result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun  <= 1'b0;
            r_out_data <= '0;
        end else begin
            if (w_trig && w_busy) r_overrun <= 1'b1;
            if (r_state == S_CAPTURE) r_out_data <= i_mac_accum;
        end
    end

    // The coefficient ROM has one cycle of latency, so the address runs one tap ahead of the data
    assign o_coef_addr  = (r_state == S_MAC) ? r_tap + 1'b1 : '0;
    assign o_mac_clr    = (r_state == S_CLEAR);
    assign o_mac_wren   = (r_state == S_MAC) || (r_state == S_FLUSH);
    assign o_mac_rden   = (r_state == S_READ);
    assign o_mac_m1     = (r_state == S_MAC) ? w_rd_data : '0;
    assign o_mac_m2     = (r_state == S_MAC) ? i_coef_data : '0;
    assign o_out_strobe = (r_state == S_CAPTURE);
    // Bypass during CAPTURE so out_data is already valid alongside its strobe
    assign o_out_data   = o_out_strobe ? i_mac_accum : r_out_data;
    assign o_busy       = w_busy;
    assign o_overrun    = r_overrun;

endmodule
